alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries (2..32).
REQ-002 Parameter XLEN, default 64, operand/result width.
REQ-003 Parameter IDX_W, default 5, register index width.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: reset is asynchronous and active-high.
REQ-006 Port enq_valid/enq_ready, input/output, 1/1: enqueue handshake; transfer when both high.
REQ-007 Port enq_opcode/enq_func3/enq_func7/enq_imm, input, 7/3/7/20: decoded fields.
REQ-008 Port enq_pc, input, XLEN: instruction PC.
REQ-009 Port enq_rd_indx/enq_rs1_indx/enq_rs2_indx, input, IDX_W each: register indices.
REQ-010 Port enq_rs1_rdy/enq_rs2_rdy, input, 1 each: operand value valid at enqueue.
REQ-011 Port enq_rs1_data/enq_rs2_data, input, XLEN each: operand values when ready.
REQ-012 Port wb_valid/wb_rd_indx/wb_data, input, 1/IDX_W/XLEN: ALU writeback broadcast for wakeup.
REQ-013 Port iss_valid, output, 1: issue strobe to ALU pipeline register (i_valid).
REQ-014 Port iss_opcode/iss_func3/iss_func7/iss_imm/iss_pc/iss_rd_indx/iss_rs1/iss_rs2, output: issued entry, widths as enqueue.
REQ-015 Port count, output, $clog2(DEPTH+1): occupied entries.

Function
REQ-016 Queue SHALL be collapsing: entry 0 oldest; on issue, entries above issued slot shift down one position same edge.
REQ-017 enq_ready SHALL equal (count < DEPTH), independent of this cycle's issue.
REQ-018 Enqueued entry SHALL land at slot count (or count-1 if an issue from a lower slot occurs same cycle).
REQ-019 Entry is ready when both operand-ready flags set; each cycle oldest ready entry SHALL be selected.
REQ-020 Issue outputs SHALL be registered: selected entry appears on iss_* the edge after selection, iss_valid high exactly one cycle per instruction; iss_valid low when no entry ready.
REQ-021 At most one issue per cycle; no backpressure on issue side.
REQ-022 Wakeup: wb_valid with wb_rd_indx != 0 SHALL set ready and capture wb_data for every stored operand with matching index and ready flag clear.
REQ-023 Same-cycle bypass: enqueued operand not ready whose index matches an active wakeup SHALL be stored ready with wb_data.
REQ-024 Source index 0 SHALL be treated ready with value 0 regardless of enq_*_rdy/data.
REQ-025 wb_rd_indx == 0 SHALL wake nothing.
REQ-026 Enqueue, wakeup and issue in one cycle SHALL all take effect; a just-enqueued entry is not selectable until the next cycle.
REQ-027 Full queue with issue in same cycle: enq_ready stays low that cycle; no entry lost or duplicated.

Reset
REQ-028 Reset SHALL clear all entry valid bits, count=0, iss_valid=0, all iss_* data outputs=0, perf counters=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued and in-flight issue state immediately; no iss_valid after reset until a new ready enqueue.

Configuration
REQ-030 Macro ALU_IQ_PERF_CNT_EN defined: add outputs perf_issued (32b, increments per iss_valid) and perf_full (32b, increments each cycle enq_valid high and enq_ready low), both wrap at 2^32.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package alu_pkg SHALL hold the entry struct typedef (fields of REQ-007..011 plus ready flags) and opcode constants.
REQ-033 One sub-module alu_iq_select: combinational oldest-ready priority encoder returning slot index and found flag.

Verification
REQ-034 Enqueue ADDI x1,x0,5 (rs1=0) into empty queue -> iss_valid 2 cycles later, iss_rs1=0, iss_imm=5, count back to 0.
REQ-035 Enqueue ADD x3,x1,x2 with rs1 not ready, then wb_valid rd=1 data=0x10 -> issue next cycle after wakeup with iss_rs1=0x10.
REQ-036 Enqueue A (not ready) then B (ready) -> B issues first; A issues after its wakeup; count sequence 1,2,1,0.
REQ-037 Enqueue with rs2=7 not ready in the same cycle as wb rd=7 data=0xAB -> entry issues next cycle with iss_rs2=0xAB.
REQ-038 Fill DEPTH=8 with not-ready entries -> enq_ready=0, count=8; with PERF_CNT_EN, perf_full increments each blocked cycle; single wakeup frees one slot.
REQ-039 Assert reset with 5 entries queued -> count=0, iss_valid=0 next cycle, no stale issue afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue queue: the stored entry layout, opcode
// constants and the operand wakeup helper used for stored and incoming entries.
package alu_pkg;

  localparam int MAX_XLEN  = 64;
  localparam int MAX_IDX_W = 5;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [19:0]          imm;
    logic [MAX_XLEN-1:0]  pc;
    logic [MAX_IDX_W-1:0] rd_indx;
    logic [MAX_IDX_W-1:0] rs1_indx;
    logic [MAX_IDX_W-1:0] rs2_indx;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
    logic [MAX_XLEN-1:0]  rs1_data;
    logic [MAX_XLEN-1:0]  rs2_data;
  } iq_entry_t;

  // Register x0 never produces a wakeup; only still-waiting operands capture data.
  function automatic iq_entry_t apply_wakeup(input iq_entry_t            e,
                                             input logic                 wb_valid,
                                             input logic [MAX_IDX_W-1:0] wb_rd_indx,
                                             input logic [MAX_XLEN-1:0]  wb_data);
    iq_entry_t r;
    r = e;
    if (wb_valid && (wb_rd_indx != '0)) begin
      if (!r.rs1_rdy && (r.rs1_indx == wb_rd_indx)) begin
        r.rs1_rdy  = 1'b1;
        r.rs1_data = wb_data;
      end
      if (!r.rs2_rdy && (r.rs2_indx == wb_rd_indx)) begin
        r.rs2_rdy  = 1'b1;
        r.rs2_data = wb_data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_iq_select.sv
// Oldest-ready picker for the collapsing issue queue: slot 0 is the oldest,
// so the lowest occupied slot with both operands ready wins.
module alu_iq_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0]         ready,
  output logic [$clog2(DEPTH)-1:0] sel_idx,
  output logic                     found
);

  localparam int SEL_W = $clog2(DEPTH);

  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && ready[i]) begin
        sel_idx = SEL_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing in-order-priority ALU issue queue with writeback wakeup and
// registered issue port. Optional counters enabled by ALU_IQ_PERF_CNT_EN.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 64,
  parameter int IDX_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [6:0]                 enq_opcode,
  input  logic [2:0]                 enq_func3,
  input  logic [6:0]                 enq_func7,
  input  logic [19:0]                enq_imm,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [IDX_W-1:0]           enq_rd_indx,
  input  logic [IDX_W-1:0]           enq_rs1_indx,
  input  logic [IDX_W-1:0]           enq_rs2_indx,
  input  logic                       enq_rs1_rdy,
  input  logic                       enq_rs2_rdy,
  input  logic [XLEN-1:0]            enq_rs1_data,
  input  logic [XLEN-1:0]            enq_rs2_data,
  input  logic                       wb_valid,
  input  logic [IDX_W-1:0]           wb_rd_indx,
  input  logic [XLEN-1:0]            wb_data,
  output logic                       iss_valid,
  output logic [6:0]                 iss_opcode,
  output logic [2:0]                 iss_func3,
  output logic [6:0]                 iss_func7,
  output logic [19:0]                iss_imm,
  output logic [XLEN-1:0]            iss_pc,
  output logic [IDX_W-1:0]           iss_rd_indx,
  output logic [XLEN-1:0]            iss_rs1,
  output logic [XLEN-1:0]            iss_rs2,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ALU_IQ_PERF_CNT_EN
  ,
  output logic [31:0]                perf_issued,
  output logic [31:0]                perf_full
`endif
);

  localparam int SEL_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  iq_entry_t            ent_q [DEPTH];
  iq_entry_t            ent_n [DEPTH];
  iq_entry_t            woken [DEPTH];
  iq_entry_t            enq_raw;
  iq_entry_t            enq_ent;
  logic [DEPTH-1:0]     slot_valid;
  logic [DEPTH-1:0]     slot_ready;
  logic [SEL_W-1:0]     sel_idx;
  logic                 sel_found;
  logic                 enq_fire;
  logic [CNT_W-1:0]     enq_slot;
  logic [CNT_W-1:0]     count_n;
  logic [MAX_IDX_W-1:0] wb_idx_ext;
  logic [MAX_XLEN-1:0]  wb_data_ext;

  assign enq_ready   = (count < CNT_W'(DEPTH));
  assign enq_fire    = enq_valid && enq_ready;
  assign wb_idx_ext  = MAX_IDX_W'(wb_rd_indx);
  assign wb_data_ext = MAX_XLEN'(wb_data);

  // Entries stay packed from slot 0, so occupancy follows directly from count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = (CNT_W'(i) < count);
      slot_ready[i] = ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
    end
  end

  alu_iq_select #(
    .DEPTH(DEPTH)
  ) u_select (
    .valid  (slot_valid),
    .ready  (slot_ready),
    .sel_idx(sel_idx),
    .found  (sel_found)
  );

  // Incoming entry: x0 sources are ready with value zero, then a same-cycle
  // writeback can still satisfy whichever operand is waiting.
  always_comb begin
    enq_raw          = '0;
    enq_raw.opcode   = enq_opcode;
    enq_raw.func3    = enq_func3;
    enq_raw.func7    = enq_func7;
    enq_raw.imm      = enq_imm;
    enq_raw.pc       = MAX_XLEN'(enq_pc);
    enq_raw.rd_indx  = MAX_IDX_W'(enq_rd_indx);
    enq_raw.rs1_indx = MAX_IDX_W'(enq_rs1_indx);
    enq_raw.rs2_indx = MAX_IDX_W'(enq_rs2_indx);
    if (enq_rs1_indx == '0) begin
      enq_raw.rs1_rdy = 1'b1;
    end else if (enq_rs1_rdy) begin
      enq_raw.rs1_rdy  = 1'b1;
      enq_raw.rs1_data = MAX_XLEN'(enq_rs1_data);
    end
    if (enq_rs2_indx == '0) begin
      enq_raw.rs2_rdy = 1'b1;
    end else if (enq_rs2_rdy) begin
      enq_raw.rs2_rdy  = 1'b1;
      enq_raw.rs2_data = MAX_XLEN'(enq_rs2_data);
    end
    enq_ent = apply_wakeup(enq_raw, wb_valid, wb_idx_ext, wb_data_ext);
  end

  // Wake, collapse above the issued slot, then append behind the survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = apply_wakeup(ent_q[i], wb_valid, wb_idx_ext, wb_data_ext);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      ent_n[i] = (sel_found && (SEL_W'(i) >= sel_idx)) ? woken[i+1] : woken[i];
    end
    ent_n[DEPTH-1] = sel_found ? '0 : woken[DEPTH-1];
    enq_slot = sel_found ? (count - CNT_W'(1)) : count;
    if (enq_fire) begin
      ent_n[SEL_W'(enq_slot)] = enq_ent;
    end
    count_n = count + CNT_W'(enq_fire) - CNT_W'(sel_found);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count <= count_n;
      ent_q <= ent_n;
    end
  end

  // The selected entry is removed and presented to the ALU on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_valid   <= 1'b0;
      iss_opcode  <= '0;
      iss_func3   <= '0;
      iss_func7   <= '0;
      iss_imm     <= '0;
      iss_pc      <= '0;
      iss_rd_indx <= '0;
      iss_rs1     <= '0;
      iss_rs2     <= '0;
    end else begin
      iss_valid <= sel_found;
      if (sel_found) begin
        iss_opcode  <= ent_q[sel_idx].opcode;
        iss_func3   <= ent_q[sel_idx].func3;
        iss_func7   <= ent_q[sel_idx].func7;
        iss_imm     <= ent_q[sel_idx].imm;
        iss_pc      <= XLEN'(ent_q[sel_idx].pc);
        iss_rd_indx <= IDX_W'(ent_q[sel_idx].rd_indx);
        iss_rs1     <= XLEN'(ent_q[sel_idx].rs1_data);
        iss_rs2     <= XLEN'(ent_q[sel_idx].rs2_data);
      end
    end
  end

`ifdef ALU_IQ_PERF_CNT_EN
  // Issued count advances on the edge that raises iss_valid; both wrap freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued <= '0;
      perf_full   <= '0;
    end else begin
      if (sel_found) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if (enq_valid && !enq_ready) begin
        perf_full <= perf_full + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized
// traffic against a queue-based reference model. Honours ALU_IQ_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 8;
  localparam int XLEN  = 64;
  localparam int IDX_W = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_valid, enq_ready;
  logic [6:0]  enq_opcode, enq_func7;
  logic [2:0]  enq_func3;
  logic [19:0] enq_imm;
  logic [63:0] enq_pc, enq_rs1_data, enq_rs2_data, wb_data;
  logic [4:0]  enq_rd_indx, enq_rs1_indx, enq_rs2_indx, wb_rd_indx;
  logic        enq_rs1_rdy, enq_rs2_rdy, wb_valid;
  logic        iss_valid;
  logic [6:0]  iss_opcode, iss_func7;
  logic [2:0]  iss_func3;
  logic [19:0] iss_imm;
  logic [63:0] iss_pc, iss_rs1, iss_rs2;
  logic [4:0]  iss_rd_indx;
  logic [3:0]  count;
`ifdef ALU_IQ_PERF_CNT_EN
  logic [31:0] perf_issued, perf_full;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rs1, rs2;
    bit          r1, r2;
    logic [63:0] d1, d2;
  } mdl_t;

  mdl_t mq[$];

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_opcode(enq_opcode), .enq_func3(enq_func3), .enq_func7(enq_func7), .enq_imm(enq_imm),
    .enq_pc(enq_pc), .enq_rd_indx(enq_rd_indx), .enq_rs1_indx(enq_rs1_indx), .enq_rs2_indx(enq_rs2_indx),
    .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy),
    .enq_rs1_data(enq_rs1_data), .enq_rs2_data(enq_rs2_data),
    .wb_valid(wb_valid), .wb_rd_indx(wb_rd_indx), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_func3(iss_func3), .iss_func7(iss_func7),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rd_indx(iss_rd_indx),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .count(count)
`ifdef ALU_IQ_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_full(perf_full)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid = 0; enq_opcode = '0; enq_func3 = '0; enq_func7 = '0; enq_imm = '0;
    enq_pc = '0; enq_rd_indx = '0; enq_rs1_indx = '0; enq_rs2_indx = '0;
    enq_rs1_rdy = 0; enq_rs2_rdy = 0; enq_rs1_data = '0; enq_rs2_data = '0;
    wb_valid = 0; wb_rd_indx = '0; wb_data = '0;
  endtask

  task automatic set_enq(input logic [6:0] opc, input logic [63:0] pc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic r1, input logic [63:0] d1,
                         input logic [4:0] rs2, input logic r2, input logic [63:0] d2,
                         input logic [19:0] imm);
    enq_valid = 1; enq_opcode = opc; enq_pc = pc; enq_rd_indx = rd;
    enq_rs1_indx = rs1; enq_rs1_rdy = r1; enq_rs1_data = d1;
    enq_rs2_indx = rs2; enq_rs2_rdy = r2; enq_rs2_data = d2; enq_imm = imm;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    reset = 1;
    #2;
    reset = 0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    #2;
    compared++; if (count !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    compared++; if (iss_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_iss_valid: got %b want 0", iss_valid); end
    tick();
    reset = 0;
    tick();
    compared++; if (enq_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_enq_ready: got %b want 1", enq_ready); end
    compared++; if ({iss_pc, iss_rs1, iss_rs2, iss_imm} !== '0) begin mismatched++; $display("[TB] FAIL reset_iss_data: got %h/%h/%h/%h want 0", iss_pc, iss_rs1, iss_rs2, iss_imm); end
`ifdef ALU_IQ_PERF_CNT_EN
    compared++; if ({perf_issued, perf_full} !== 64'd0) begin mismatched++; $display("[TB] FAIL reset_perf: got %0d/%0d want 0/0", perf_issued, perf_full); end
`endif
  endtask

  task automatic test_addi();
    do_reset();
    set_enq(OPC_OP_IMM, 64'h1000, 5'd1, 5'd0, 0, 64'h0, 5'd0, 0, 64'h0, 20'd5);
    tick();
    idle();
    compared++; if (count !== 4'd1 || iss_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL addi_enq: got count %0d valid %b want 1/0", count, iss_valid); end
    tick();
    compared++; if (iss_valid !== 1'b1 || iss_rs1 !== 64'd0 || iss_imm !== 20'd5) begin mismatched++; $display("[TB] FAIL addi_issue: got valid %b rs1 %h imm %h want 1/0/5", iss_valid, iss_rs1, iss_imm); end
    compared++; if (count !== 4'd0 || iss_opcode !== OPC_OP_IMM || iss_rd_indx !== 5'd1) begin mismatched++; $display("[TB] FAIL addi_fields: got count %0d opc %h rd %0d want 0/13/1", count, iss_opcode, iss_rd_indx); end
    tick();
    compared++; if (iss_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL addi_single_pulse: got %b want 0", iss_valid); end
  endtask

  task automatic test_wakeup();
    do_reset();
    set_enq(OPC_OP, 64'h2000, 5'd3, 5'd1, 0, 64'h0, 5'd2, 1, 64'h7, 20'd0);
    tick();
    idle();
    wb_valid = 1; wb_rd_indx = 5'd1; wb_data = 64'h10;
    tick();
    idle();
    compared++; if (iss_valid !== 1'b0 || count !== 4'd1) begin mismatched++; $display("[TB] FAIL wake_wait: got valid %b count %0d want 0/1", iss_valid, count); end
    tick();
    compared++; if (iss_valid !== 1'b1 || iss_rs1 !== 64'h10 || iss_rs2 !== 64'h7 || iss_rd_indx !== 5'd3) begin mismatched++; $display("[TB] FAIL wake_issue: got valid %b rs1 %h rs2 %h rd %0d want 1/10/7/3", iss_valid, iss_rs1, iss_rs2, iss_rd_indx); end
    compared++; if (count !== 4'd0) begin mismatched++; $display("[TB] FAIL wake_count: got %0d want 0", count); end
  endtask

  task automatic test_order();
    do_reset();
    set_enq(OPC_OP, 64'hA00, 5'd5, 5'd4, 0, 64'h0, 5'd0, 0, 64'h0, 20'd0);
    tick();
    compared++; if (count !== 4'd1) begin mismatched++; $display("[TB] FAIL order_count1: got %0d want 1", count); end
    set_enq(OPC_OP, 64'hB00, 5'd6, 5'd0, 0, 64'h0, 5'd0, 0, 64'h0, 20'd0);
    tick();
    idle();
    compared++; if (count !== 4'd2 || iss_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL order_count2: got count %0d valid %b want 2/0", count, iss_valid); end
    tick();
    compared++; if (iss_valid !== 1'b1 || iss_pc !== 64'hB00 || count !== 4'd1) begin mismatched++; $display("[TB] FAIL order_b_first: got valid %b pc %h count %0d want 1/b00/1", iss_valid, iss_pc, count); end
    wb_valid = 1; wb_rd_indx = 5'd4; wb_data = 64'h44;
    tick();
    idle();
    compared++; if (iss_valid !== 1'b0 || count !== 4'd1) begin mismatched++; $display("[TB] FAIL order_gap: got valid %b count %0d want 0/1", iss_valid, count); end
    tick();
    compared++; if (iss_valid !== 1'b1 || iss_pc !== 64'hA00 || iss_rs1 !== 64'h44 || count !== 4'd0) begin mismatched++; $display("[TB] FAIL order_a_second: got valid %b pc %h rs1 %h count %0d want 1/a00/44/0", iss_valid, iss_pc, iss_rs1, count); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_enq(OPC_OP, 64'h3000, 5'd8, 5'd0, 0, 64'hDEAD, 5'd7, 0, 64'h0, 20'd0);
    wb_valid = 1; wb_rd_indx = 5'd7; wb_data = 64'hAB;
    tick();
    idle();
    compared++; if (count !== 4'd1) begin mismatched++; $display("[TB] FAIL bypass_count: got %0d want 1", count); end
    tick();
    compared++; if (iss_valid !== 1'b1 || iss_rs2 !== 64'hAB || iss_rs1 !== 64'd0) begin mismatched++; $display("[TB] FAIL bypass_issue: got valid %b rs1 %h rs2 %h want 1/0/ab", iss_valid, iss_rs1, iss_rs2); end
  endtask

  task automatic test_full();
`ifdef ALU_IQ_PERF_CNT_EN
    logic [31:0] perf0;
`endif
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(OPC_OP, 64'h100 + 64'(i), 5'd1, 5'(10 + i), 0, 64'h0, 5'd0, 0, 64'h0, 20'd0);
      tick();
    end
    set_enq(OPC_OP, 64'h200, 5'd1, 5'd20, 0, 64'h0, 5'd0, 0, 64'h0, 20'd0);
    compared++; if (count !== 4'd8 || enq_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL full_state: got count %0d ready %b want 8/0", count, enq_ready); end
`ifdef ALU_IQ_PERF_CNT_EN
    perf0 = perf_full;
`endif
    repeat (3) tick();
    wb_valid = 1; wb_rd_indx = 5'd10; wb_data = 64'h55;
    tick();
    wb_valid = 0;
    compared++; if (enq_ready !== 1'b0 || iss_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_wake_cycle: got ready %b valid %b want 0/0", enq_ready, iss_valid); end
    tick();
    idle();
    compared++; if (iss_valid !== 1'b1 || iss_pc !== 64'h100 || iss_rs1 !== 64'h55) begin mismatched++; $display("[TB] FAIL full_issue: got valid %b pc %h rs1 %h want 1/100/55", iss_valid, iss_pc, iss_rs1); end
    compared++; if (count !== 4'd7 || enq_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL full_free_slot: got count %0d ready %b want 7/1", count, enq_ready); end
`ifdef ALU_IQ_PERF_CNT_EN
    compared++; if (perf_full !== perf0 + 32'd5 || perf_issued !== 32'd1) begin mismatched++; $display("[TB] FAIL full_perf: got full %0d issued %0d want %0d/1", perf_full, perf_issued, perf0 + 32'd5); end
`endif
    wb_valid = 1; wb_rd_indx = 5'd11; wb_data = 64'h66;
    tick();
    idle();
    compared++; if (count !== 4'd7 || iss_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_no_dup: got count %0d valid %b want 7/0", count, iss_valid); end
    tick();
    compared++; if (iss_valid !== 1'b1 || iss_pc !== 64'h101 || iss_rs1 !== 64'h66 || count !== 4'd6) begin mismatched++; $display("[TB] FAIL full_collapse: got valid %b pc %h rs1 %h count %0d want 1/101/66/6", iss_valid, iss_pc, iss_rs1, count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_enq(OPC_OP, 64'h400 + 64'(i), 5'd2, 5'(3 + i), 0, 64'h0, 5'd0, 0, 64'h0, 20'd0);
      tick();
    end
    set_enq(OPC_OP, 64'h410, 5'd2, 5'd0, 0, 64'h0, 5'd0, 0, 64'h0, 20'd0);
    tick();
    set_enq(OPC_OP, 64'h411, 5'd2, 5'd0, 0, 64'h0, 5'd0, 0, 64'h0, 20'd0);
    tick();
    idle();
    compared++; if (count !== 4'd4 || iss_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_pre_reset: got count %0d valid %b want 4/1", count, iss_valid); end
    #2;
    reset = 1;
    #1;
    compared++; if (count !== 4'd0 || iss_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_async: got count %0d valid %b want 0/0", count, iss_valid); end
    tick();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1; wb_rd_indx = 5'(3 + i); wb_data = 64'h77;
      tick();
      compared++; if (iss_valid !== 1'b0 || count !== 4'd0) begin mismatched++; $display("[TB] FAIL mid_stale_issue: got valid %b count %0d want 0/0", iss_valid, count); end
    end
    idle();
    set_enq(OPC_OP, 64'h500, 5'd9, 5'd0, 0, 64'h0, 5'd0, 0, 64'h0, 20'd0);
    tick();
    idle();
    tick();
    compared++; if (iss_valid !== 1'b1 || iss_pc !== 64'h500) begin mismatched++; $display("[TB] FAIL mid_recover: got valid %b pc %h want 1/500", iss_valid, iss_pc); end
  endtask

  task automatic test_random(input int cycles);
    mdl_t        m;
    mdl_t        hit;
    bit          have;
    bit          exp_ready;
    int          pick;
    logic [63:0] pc_seq;
    do_reset();
    mq.delete();
    pc_seq = 64'h8000;
    hit = '{default: '0};
    for (int c = 0; c < cycles; c++) begin
      enq_valid    = ($urandom_range(0, 99) < 55);
      enq_opcode   = OPC_OP;
      enq_func3    = 3'($urandom);
      enq_func7    = 7'($urandom);
      enq_imm      = 20'($urandom);
      enq_pc       = pc_seq;
      enq_rd_indx  = 5'($urandom_range(0, 31));
      enq_rs1_indx = 5'($urandom_range(0, 7));
      enq_rs2_indx = 5'($urandom_range(0, 7));
      enq_rs1_rdy  = 1'($urandom_range(0, 1));
      enq_rs2_rdy  = 1'($urandom_range(0, 1));
      enq_rs1_data = {$urandom, $urandom};
      enq_rs2_data = {$urandom, $urandom};
      wb_valid     = ($urandom_range(0, 99) < 45);
      wb_rd_indx   = 5'($urandom_range(0, 7));
      wb_data      = {$urandom, $urandom};

      exp_ready = (mq.size() < DEPTH);
      compared++; if (enq_ready !== exp_ready) begin mismatched++; $display("[TB] FAIL rand_enq_ready cyc %0d: got %b want %b", c, enq_ready, exp_ready); end

      have = 0;
      pick = 0;
      foreach (mq[k]) if (!have && mq[k].r1 && mq[k].r2) begin have = 1; pick = k; end
      if (have) begin
        hit = mq[pick];
        mq.delete(pick);
      end
      if (wb_valid && wb_rd_indx != 0) begin
        foreach (mq[k]) begin
          if (!mq[k].r1 && mq[k].rs1 == wb_rd_indx) begin mq[k].r1 = 1; mq[k].d1 = wb_data; end
          if (!mq[k].r2 && mq[k].rs2 == wb_rd_indx) begin mq[k].r2 = 1; mq[k].d2 = wb_data; end
        end
      end
      if (enq_valid && exp_ready) begin
        m.pc = enq_pc; m.rs1 = enq_rs1_indx; m.rs2 = enq_rs2_indx;
        if (enq_rs1_indx == 0) begin m.r1 = 1; m.d1 = 0; end
        else if (enq_rs1_rdy) begin m.r1 = 1; m.d1 = enq_rs1_data; end
        else if (wb_valid && wb_rd_indx == enq_rs1_indx) begin m.r1 = 1; m.d1 = wb_data; end
        else begin m.r1 = 0; m.d1 = 0; end
        if (enq_rs2_indx == 0) begin m.r2 = 1; m.d2 = 0; end
        else if (enq_rs2_rdy) begin m.r2 = 1; m.d2 = enq_rs2_data; end
        else if (wb_valid && wb_rd_indx == enq_rs2_indx) begin m.r2 = 1; m.d2 = wb_data; end
        else begin m.r2 = 0; m.d2 = 0; end
        mq.push_back(m);
        pc_seq = pc_seq + 64'd4;
      end

      tick();

      compared++; if (iss_valid !== have) begin mismatched++; $display("[TB] FAIL rand_iss_valid cyc %0d: got %b want %b", c, iss_valid, have); end
      if (have) begin
        compared++; if (iss_pc !== hit.pc || iss_rs1 !== hit.d1 || iss_rs2 !== hit.d2) begin mismatched++; $display("[TB] FAIL rand_iss_data cyc %0d: got pc %h rs1 %h rs2 %h want %h/%h/%h", c, iss_pc, iss_rs1, iss_rs2, hit.pc, hit.d1, hit.d2); end
      end
      compared++; if (count !== 4'(mq.size())) begin mismatched++; $display("[TB] FAIL rand_count cyc %0d: got %0d want %0d", c, count, mq.size()); end
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_addi();
    test_wakeup();
    test_order();
    test_bypass();
    test_full();
    test_reset_mid();
    test_random(600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
